multi_button_debouncer: RTL

MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

---
 rtl/multi_button_debouncer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - multi-button debouncer with press lockout and event handshake
//
// Purpose: debounces NUM_BUTTONS raw button inputs. It accepts one press at a
// time through a lockout FSM and offers each accepted press as an event on a
// valid/ready handshake.
//
// Ports:
//   clk         - single clock; all state updates on the rising edge
//   rst_n       - asynchronous active-low reset
//   btn         - raw asynchronous bouncing button levels
//   btn_db      - debounced button levels
//   lock_active - a press was accepted and not all buttons have been released yet
//   evt_valid   - a press event is pending
//   evt_id      - index of the pressed button (meaningful while evt_valid=1)
//   evt_ready   - consumer accepts the pending event
//   overflow    - sticky; a press was accepted while an earlier event was still pending
module multi_button_debouncer #(
  parameter int NUM_BUTTONS   = 2,
  parameter int STABLE_CYCLES = 4,
  localparam int ID_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn,
  output logic [NUM_BUTTONS-1:0] btn_db,
  output logic                   lock_active,
  output logic                   evt_valid,
  output logic [ID_W-1:0]        evt_id,
  input  logic                   evt_ready,
  output logic                   overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // The counter reaches STABLE_CYCLES-1 after that many differing edges.
  // The next differing edge is the accepting one.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [7:0]             cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] commit;
  logic [NUM_BUTTONS-1:0] rise;

  state_t                 state;
  state_t                 state_next;
  logic                   gen;
  logic [ID_W-1:0]        gen_id;

  // Two-flop synchronizer for each raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // commit: this edge is the STABLE_CYCLES-th consecutive disagreement.
  // rise: the subset of commits that take btn_db from 0 to 1.
  always_comb begin
    commit = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      commit[i] = (sync2[i] != btn_db[i]) && (cnt[i] == CNT_LAST);
    end
    rise = commit & sync2 & ~btn_db;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (sync2[i] == btn_db[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          btn_db[i] <= sync2[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != 8'hFF) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The descending scan leaves the lowest-index rising button in gen_id.
  // The release check uses registered btn_db, so HELD exits one edge after all
  // buttons have settled low.
  always_comb begin
    state_next  = state;
    gen         = 1'b0;
    gen_id      = '0;
    lock_active = (state == HELD);
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        gen_id = ID_W'(i);
      end
    end
    case (state)
      IDLE: begin
        if (|rise) begin
          gen        = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (btn_db == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new event can replace a pending one only on an edge where the pending
  // one is handed off. Otherwise the new event is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      overflow  <= 1'b0;
    end else if (gen) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_id    <= gen_id;
      end else begin
        overflow <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
